// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - fetch/decode/execute sequencer for the 16-bit processor control unit
module control_fsm #(
  parameter int INSTR_W  = 16,
  parameter int DADDR_W  = 8,
  parameter int RADDR_W  = 4,
  parameter int ALUSEL_W = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [INSTR_W-1:0]  InstrIn,
  output logic                PC_clr,
  output logic                PC_up,
  output logic [INSTR_W-1:0]  IR,
  output logic [DADDR_W-1:0]  D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic [RADDR_W-1:0]  RF_W_addr,
  output logic                RF_W_en,
  output logic [RADDR_W-1:0]  RF_Ra_addr,
  output logic [RADDR_W-1:0]  RF_Rb_addr,
  output logic [ALUSEL_W-1:0] ALU_s0,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    SUB    = 4'd8,
    HALT   = 4'd9
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [INSTR_W-1:0]   ir_nxt;

  logic                 pc_clr_nxt;
  logic                 pc_up_nxt;
  logic [DADDR_W-1:0]   d_addr_nxt;
  logic                 d_wr_nxt;
  logic                 rf_s_nxt;
  logic [RADDR_W-1:0]   rf_w_addr_nxt;
  logic                 rf_w_en_nxt;
  logic [RADDR_W-1:0]   rf_ra_addr_nxt;
  logic [RADDR_W-1:0]   rf_rb_addr_nxt;
  logic [ALUSEL_W-1:0]  alu_s0_nxt;

  assign State = state;

  // Next state and IR: IR only loads on the edge that leaves FETCH; DECODE branches on the opcode
  always_comb begin
    state_nxt = INIT;
    ir_nxt    = IR;
    case (state)
      INIT:   state_nxt = FETCH;
      FETCH: begin
        state_nxt = DECODE;
        ir_nxt    = InstrIn;
      end
      DECODE: begin
        case (IR[15:12])
          4'b0000: state_nxt = NOOP;
          4'b0001: state_nxt = STORE;
          4'b0010: state_nxt = LOAD_A;
          4'b0011: state_nxt = ADD;
          4'b0100: state_nxt = SUB;
          4'b0101: state_nxt = HALT;
          default: state_nxt = NOOP;
        endcase
      end
      NOOP:   state_nxt = FETCH;
      LOAD_A: state_nxt = LOAD_B;
      LOAD_B: state_nxt = FETCH;
      STORE:  state_nxt = FETCH;
      ADD:    state_nxt = FETCH;
      SUB:    state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = INIT;
    endcase
  end

  // Output decode of the upcoming state so the registered outputs line up with State
  always_comb begin
    pc_clr_nxt     = 1'b0;
    pc_up_nxt      = 1'b0;
    d_addr_nxt     = '0;
    d_wr_nxt       = 1'b0;
    rf_s_nxt       = 1'b0;
    rf_w_addr_nxt  = '0;
    rf_w_en_nxt    = 1'b0;
    rf_ra_addr_nxt = '0;
    rf_rb_addr_nxt = '0;
    alu_s0_nxt     = '0;
    case (state_nxt)
      INIT:  pc_clr_nxt = 1'b1;
      FETCH: pc_up_nxt  = 1'b1;
      STORE: begin
        d_addr_nxt     = ir_nxt[7:0];
        rf_ra_addr_nxt = ir_nxt[11:8];
        d_wr_nxt       = 1'b1;
      end
      LOAD_A: begin
        // Memory data is not valid yet, so the write waits for LOAD_B
        d_addr_nxt    = ir_nxt[11:4];
        rf_s_nxt      = 1'b1;
        rf_w_addr_nxt = ir_nxt[3:0];
      end
      LOAD_B: begin
        d_addr_nxt    = ir_nxt[11:4];
        rf_s_nxt      = 1'b1;
        rf_w_addr_nxt = ir_nxt[3:0];
        rf_w_en_nxt   = 1'b1;
      end
      ADD: begin
        rf_ra_addr_nxt = ir_nxt[11:8];
        rf_rb_addr_nxt = ir_nxt[7:4];
        rf_w_addr_nxt  = ir_nxt[3:0];
        alu_s0_nxt     = ALUSEL_W'(1);
        rf_w_en_nxt    = 1'b1;
      end
      SUB: begin
        rf_ra_addr_nxt = ir_nxt[11:8];
        rf_rb_addr_nxt = ir_nxt[7:4];
        rf_w_addr_nxt  = ir_nxt[3:0];
        alu_s0_nxt     = ALUSEL_W'(2);
        rf_w_en_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, IR and all outputs registered together; Reset forces INIT from any state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= INIT;
      IR         <= '0;
      PC_clr     <= 1'b1;
      PC_up      <= 1'b0;
      D_addr     <= '0;
      D_wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_addr  <= '0;
      RF_W_en    <= 1'b0;
      RF_Ra_addr <= '0;
      RF_Rb_addr <= '0;
      ALU_s0     <= '0;
    end else begin
      state      <= state_nxt;
      IR         <= ir_nxt;
      PC_clr     <= pc_clr_nxt;
      PC_up      <= pc_up_nxt;
      D_addr     <= d_addr_nxt;
      D_wr       <= d_wr_nxt;
      RF_s       <= rf_s_nxt;
      RF_W_addr  <= rf_w_addr_nxt;
      RF_W_en    <= rf_w_en_nxt;
      RF_Ra_addr <= rf_ra_addr_nxt;
      RF_Rb_addr <= rf_rb_addr_nxt;
      ALU_s0     <= alu_s0_nxt;
    end
  end

endmodule
